// File: rtl/fetch_refill_ctrl.sv
// fetch_refill_ctrl: I-cache miss/refill sequencer for the fetch stage.
// Stalls fetch on a miss, requests the aligned line, streams beats into the
// data array, then writes the tag so fetch replays the same PC.
// Ports: i_clk/i_arst (async, active-high), i_fetch_en/i_pc/i_hit from fetch,
// o_stall_fetch to PC/decode regs, o_mem_ar*/i_mem_r* to the next level,
// o_line_we/o_line_idx/o_line_wdata and o_tag_we to the cache arrays.
// Option: define FETCH_REFILL_PERF_EN to add o_miss_cnt / o_stall_cnt.
module fetch_refill_ctrl #(
   parameter int ADDR_WIDTH  = 64,
   parameter int WORD_WIDTH  = 32,
   parameter int BLOCK_WORDS = 16,
   localparam int OFFSET = $clog2(BLOCK_WORDS * WORD_WIDTH / 8),
   localparam int IDX_W  = $clog2(BLOCK_WORDS)
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic                  i_fetch_en,
   input  logic [ADDR_WIDTH-1:0] i_pc,
   input  logic                  i_hit,
   output logic                  o_stall_fetch,
   output logic                  o_mem_arvalid,
   input  logic                  i_mem_arready,
   output logic [ADDR_WIDTH-1:0] o_mem_araddr,
   input  logic                  i_mem_rvalid,
   output logic                  o_mem_rready,
   input  logic [WORD_WIDTH-1:0] i_mem_rdata,
   output logic                  o_line_we,
   output logic [IDX_W-1:0]      o_line_idx,
   output logic [WORD_WIDTH-1:0] o_line_wdata,
`ifdef FETCH_REFILL_PERF_EN
   output logic [31:0]           o_miss_cnt,
   output logic [31:0]           o_stall_cnt,
`endif
   output logic                  o_tag_we
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(BLOCK_WORDS - 1);

   state_t                  state;
   state_t                  state_nxt;
   logic [IDX_W-1:0]        beat_cnt;
   logic [ADDR_WIDTH-1:0]   miss_addr;
   logic                    miss;
   logic                    beat;

   // Offset bits of the PC never reach the line address.
   logic unused_pc_low;
   assign unused_pc_low = ^i_pc[OFFSET-1:0];

   assign miss = i_fetch_en & ~i_hit;
   assign beat = (state == FILL) & i_mem_rvalid;

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         miss_addr <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && miss)
            miss_addr <= {i_pc[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
         // Power-of-two line: natural wrap returns the count to 0 at DONE.
         if (beat)
            beat_cnt <= beat_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt     = state;
      o_stall_fetch = 1'b0;
      o_mem_arvalid = 1'b0;
      o_mem_araddr  = '0;
      o_mem_rready  = 1'b0;
      o_line_we     = 1'b0;
      o_line_idx    = '0;
      o_line_wdata  = '0;
      o_tag_we      = 1'b0;
      unique case (state)
         IDLE: begin
            // Stall on the miss cycle itself, before the FSM moves.
            if (miss) begin
               o_stall_fetch = 1'b1;
               state_nxt     = REQ;
            end
         end
         REQ: begin
            o_stall_fetch = 1'b1;
            o_mem_arvalid = 1'b1;
            o_mem_araddr  = miss_addr;
            if (i_mem_arready)
               state_nxt = FILL;
         end
         FILL: begin
            o_stall_fetch = 1'b1;
            o_mem_rready  = 1'b1;
            if (i_mem_rvalid) begin
               o_line_we    = 1'b1;
               o_line_idx   = beat_cnt;
               o_line_wdata = i_mem_rdata;
               if (beat_cnt == LAST)
                  state_nxt = DONE;
            end
         end
         DONE: begin
            o_stall_fetch = 1'b1;
            o_tag_we      = 1'b1;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef FETCH_REFILL_PERF_EN
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         o_miss_cnt  <= '0;
         o_stall_cnt <= '0;
      end else begin
         if (state == IDLE && miss)
            o_miss_cnt <= o_miss_cnt + 32'd1;
         if (o_stall_fetch)
            o_stall_cnt <= o_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_refill_ctrl.sv
// tb_fetch_refill_ctrl: directed self-checking bench for fetch_refill_ctrl.
// Cycle-stepped stimulus; outputs are checked 2ns after each rising edge.
module tb_fetch_refill_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic [63:0] pc;
   logic        hit;
   logic        stall;
   logic        arvalid;
   logic        arready;
   logic [63:0] araddr;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic        line_we;
   logic [3:0]  line_idx;
   logic [31:0] line_wdata;
   logic        tag_we;
`ifdef FETCH_REFILL_PERF_EN
   logic [31:0] miss_cnt;
   logic [31:0] stall_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_refill_ctrl dut (
      .i_clk         (clk),
      .i_arst        (rst),
      .i_fetch_en    (fetch_en),
      .i_pc          (pc),
      .i_hit         (hit),
      .o_stall_fetch (stall),
      .o_mem_arvalid (arvalid),
      .i_mem_arready (arready),
      .o_mem_araddr  (araddr),
      .i_mem_rvalid  (rvalid),
      .o_mem_rready  (rready),
      .i_mem_rdata   (rdata),
      .o_line_we     (line_we),
      .o_line_idx    (line_idx),
      .o_line_wdata  (line_wdata),
`ifdef FETCH_REFILL_PERF_EN
      .o_miss_cnt    (miss_cnt),
      .o_stall_cnt   (stall_cnt),
`endif
      .o_tag_we      (tag_we)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_in();
      fetch_en = 1'b1;
      hit      = 1'b1;
      arready  = 1'b0;
      rvalid   = 1'b0;
      rdata    = '0;
   endtask

   // One complete miss: miss cycle, REQ (with arready after ar_wait cycles),
   // FILL (rvalid dropped every 3rd cycle when gaps), DONE. Returns just
   // after the DONE edge. pc2 is driven on i_pc during FILL.
   task automatic miss(input logic [63:0] pc0, input logic [63:0] pc2,
                       input logic [63:0] exp_addr, input int ar_wait,
                       input bit gaps, input logic [31:0] seed);
      int beats;
      int cyc;
      bit v;
      fetch_en = 1'b1;
      pc       = pc0;
      hit      = 1'b0;
      arready  = 1'b1;
      rvalid   = 1'b1;
      settle();
      chk("miss_stall", stall, 1);
      chk("miss_arvalid", arvalid, 0);
      chk("miss_we", line_we, 0);
      tick();
      for (int w = 0; w <= ar_wait; w++) begin
         arready = (w == ar_wait);
         rvalid  = 1'b1;
         settle();
         chk("req_arvalid", arvalid, 1);
         chk("req_araddr", araddr, exp_addr);
         chk("req_stall", stall, 1);
         chk("req_we", line_we, 0);
         tick();
      end
      beats = 0;
      cyc   = 0;
      pc    = pc2;
      while (beats < 16 && cyc < 100) begin
         v       = !(gaps && (cyc % 3 == 2));
         arready = 1'b1;
         rvalid  = v;
         rdata   = seed + 32'(beats);
         settle();
         chk("fill_rready", rready, 1);
         chk("fill_arvalid", arvalid, 0);
         chk("fill_we", line_we, v);
         chk("fill_tag", tag_we, 0);
         chk("fill_stall", stall, 1);
         if (v) begin
            chk("fill_idx", line_idx, 64'(beats));
            chk("fill_data", line_wdata, seed + 32'(beats));
         end
         tick();
         beats += int'(v);
         cyc++;
      end
      chk("fill_beats", 64'(beats), 64'd16);
      rvalid  = 1'b1;
      arready = 1'b1;
      settle();
      chk("done_tag", tag_we, 1);
      chk("done_stall", stall, 1);
      chk("done_we", line_we, 0);
      chk("done_rready", rready, 0);
      tick();
      rvalid  = 1'b0;
      arready = 1'b0;
   endtask

   task automatic replay_hit();
      hit = 1'b1;
      settle();
      chk("replay_stall", stall, 0);
      chk("replay_tag", tag_we, 0);
      chk("replay_arvalid", arvalid, 0);
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_in();
      pc = '0;
      tick();
      tick();
      rst = 1'b0;
      settle();
   endtask

   initial begin
      do_reset();
      fetch_en = 1'b0;
      settle();
      chk("rst_stall", stall, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_tag", tag_we, 0);
      chk("rst_we", line_we, 0);
`ifdef FETCH_REFILL_PERF_EN
      chk("rst_miss_cnt", miss_cnt, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
`endif

      // 1: steady hits never stall or request.
      idle_in();
      pc = 64'h100;
      for (int i = 0; i < 20; i++) begin
         arready = i[0];
         rvalid  = i[1];
         settle();
         chk("hit_stall", stall, 0);
         chk("hit_arvalid", arvalid, 0);
         chk("hit_we", line_we, 0);
         tick();
         pc = pc + 64'd4;
      end

      // 2: zero-wait refill, tag write exactly 18 cycles after the miss.
      miss(64'h1234, 64'h1234, 64'h1200, 0, 1'b0, 32'hC0DE_0000);
      replay_hit();

      // 3: delayed arready and rvalid gaps.
      miss(64'h2F7C, 64'h2F7C, 64'h2F40, 5, 1'b1, 32'hBEEF_0100);
      replay_hit();

      // 4: PC redirect during FILL is ignored; new miss afterwards.
      miss(64'h1234, 64'h8000, 64'h1200, 0, 1'b0, 32'h1111_0000);
      miss(64'h8000, 64'h8000, 64'h8000, 1, 1'b0, 32'h2222_0000);
      replay_hit();

      // 5: reset after beat 7 of FILL.
      pc      = 64'h4444;
      hit     = 1'b0;
      arready = 1'b1;
      settle();
      chk("r5_miss", stall, 1);
      tick();
      settle();
      chk("r5_req", araddr, 64'h4440);
      tick();
      for (int b = 0; b < 8; b++) begin
         rvalid = 1'b1;
         rdata  = 32'h5500_0000 + 32'(b);
         settle();
         chk("r5_idx", line_idx, 64'(b));
         tick();
      end
      rst = 1'b1;
      settle();
      chk("r5_arst_stall", stall, 1);
      chk("r5_arst_we", line_we, 0);
      chk("r5_arst_rready", rready, 0);
      chk("r5_arst_tag", tag_we, 0);
      hit = 1'b1;
      settle();
      chk("r5_arst_idle", stall, 0);
      tick();
      settle();
      chk("r5_hold_tag", tag_we, 0);
      rst = 1'b0;
      tick();
      settle();
      chk("r5_post_tag", tag_we, 0);
      chk("r5_post_arvalid", arvalid, 0);
      miss(64'h4444, 64'h4444, 64'h4440, 0, 1'b0, 32'h6600_0000);
      replay_hit();

`ifdef FETCH_REFILL_PERF_EN
      // 6: two back-to-back zero-wait misses -> 2 misses, 38 stall cycles.
      do_reset();
      miss(64'h1234, 64'h1234, 64'h1200, 0, 1'b0, 32'hC0DE_0000);
      replay_hit();
      miss(64'h1234, 64'h1234, 64'h1200, 0, 1'b0, 32'hC0DE_0000);
      replay_hit();
      chk("perf_miss_cnt", miss_cnt, 2);
      chk("perf_stall_cnt", stall_cnt, 38);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
